pipeline_ctrl: RTL and testbench
================================

Name: pipeline_ctrl

Overview:
- Central hazard and sequencing controller for the 5-stage in-order pipeline.
- Observes decode-stage operand usage, the EX-stage load and branch status, and the data-memory busy flag. Generates the stall, bubble and flush controls for the PC, IF/ID, ID/EX and EX/MEM registers.
- Sequences the EBREAK halt: drains older instructions, then freezes the core.
- Keeps stall and flush performance counters.

Parameters:
- DRAIN_DEPTH, 3: cycles needed to retire instructions older than EBREAK (EX, MEM, WB).
- CNT_W, 32: width of the performance counters.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  reset, asynchronous, active-low (0 = reset)
- id_valid_inst  in  1  ID holds a valid decoded instruction
- id_ra_idx  in  5  ID rs1 index
- id_rb_idx  in  5  ID rs2 index
- id_uses_ra  in  1  ID instruction reads rs1
- id_uses_rb  in  1  ID instruction reads rs2
- id_halt  in  1  ID instruction is EBREAK
- ex_valid_inst  in  1  EX holds a valid instruction
- ex_rd_mem  in  1  EX instruction is a load
- ex_dest_reg_idx  in  5  EX destination index
- ex_take_branch  in  1  EX resolved a taken branch or jump
- mem_busy  in  1  data memory not ready; MEM must hold
- pc_stall  out  1  hold the PC
- if_id_stall  out  1  hold the IF/ID register
- if_id_flush  out  1  load a NOP (valid=0) into IF/ID
- id_ex_bubble  out  1  load a NOP (valid=0) into ID/EX
- ex_mem_stall  out  1  hold ID/EX, EX/MEM and MEM/WB
- halted  out  1  core is frozen after EBREAK
- state_out  out  2  current FSM state, for debug
- stall_cnt  out  CNT_W  cycles with pc_stall=1 while not HALTED
- flush_cnt  out  CNT_W  taken-branch flushes performed

Behaviour:
- Reset (rst=0, async):
  - state=RUN, drain counter=0, halted=0, stall_cnt=0, flush_cnt=0.
  - All combinational controls read 0 while rst=0.
- States: RUN=0, MEM_WAIT=1, DRAIN=2, HALTED=3.
- Hazard terms (combinational):
  - load_use = id_valid_inst & ex_valid_inst & ex_rd_mem & (ex_dest_reg_idx!=0) & ((id_uses_ra & id_ra_idx==ex_dest_reg_idx) | (id_uses_rb & id_rb_idx==ex_dest_reg_idx)).
  - br = ex_valid_inst & ex_take_branch.
- Priority in RUN/MEM_WAIT: mem_busy > br > load_use > id_halt.
  - mem_busy=1:
    - Outputs: pc_stall=if_id_stall=ex_mem_stall=1; flush=bubble=0.
    - br and halt are not acted on this cycle; EX is held, so they are re-evaluated on release.
    - Next state MEM_WAIT.
  - mem_busy=0 and br:
    - Outputs: if_id_flush=1, id_ex_bubble=1, pc_stall=0 (PC loads the target).
    - flush_cnt+1. A load_use or id_halt in the same cycle is discarded (younger instruction).
  - load_use only:
    - Outputs: pc_stall=if_id_stall=id_ex_bubble=1, held for exactly one cycle.
    - The next cycle sees EX=bubble, so the hazard clears.
  - id_valid_inst & id_halt, no higher event:
    - Outputs: pc_stall=if_id_stall=id_ex_bubble=1.
    - Load drain counter with DRAIN_DEPTH-1; next state DRAIN.
- MEM_WAIT → RUN on the first cycle mem_busy=0. That cycle is evaluated with RUN rules (zero-latency release).
- DRAIN:
  - pc_stall=if_id_stall=id_ex_bubble=1; ex_take_branch is ignored.
  - mem_busy=1 additionally asserts ex_mem_stall and freezes the counter.
  - Otherwise the counter decrements each cycle. When the counter is 0 and mem_busy=0, next state HALTED.
- HALTED:
  - pc_stall=if_id_stall=ex_mem_stall=1, halted=1.
  - All inputs are ignored; exit only via rst.
- stall_cnt: +1 on every cycle with pc_stall=1 and state!=HALTED. Counters wrap at 2^CNT_W.
- Register updates occur on the rising clk edge; the async reset dominates at any point, including mid-DRAIN.

Decomposition:
- Shared package (sys_defs):
  - state encoding constants CTRL_RUN, CTRL_MEM_WAIT, CTRL_DRAIN, CTRL_HALTED.
  - ZERO_REG, TRUE and FALSE reused.
- Optional sub-module hazard_detect: pure-combinational load_use comparator. FSM and counters stay in pipeline_ctrl.

Test Plan:
- Reset: hold rst=0 for 3 cycles with random inputs → all outputs 0; state_out=0; counters 0.
- Load-use: EX load to x5 (ex_rd_mem=1, dest=5), ID reads rs1=5 → one cycle of pc_stall=if_id_stall=id_ex_bubble=1, stall_cnt=1. Same case with dest=0 → no stall.
- Branch beats load-use: br=1 and load_use=1 in the same cycle → if_id_flush=1, id_ex_bubble=1, pc_stall=0, flush_cnt=1.
- Memory wait: mem_busy=1 for 4 cycles with br=1 held → ex_mem_stall=1 for 4 cycles, no flush. Cycle 5: flush pulse, state RUN, stall_cnt=4.
- Halt: EBREAK in ID, DRAIN_DEPTH=3 → DRAIN for 3 cycles, then halted=1 from cycle 4 onward. ex_take_branch=1 during DRAIN → no flush.
- Reset mid-DRAIN: drop rst during cycle 2 of DRAIN → immediate RUN, halted=0. After release, normal flow resumes.

Source files
------------

// File: rtl/sys_defs.sv
// Shared encodings for the pipeline hazard/sequencing controller.
package sys_defs;

    typedef enum logic [1:0] {
        CTRL_RUN      = 2'd0,
        CTRL_MEM_WAIT = 2'd1,
        CTRL_DRAIN    = 2'd2,
        CTRL_HALTED   = 2'd3
    } ctrl_state_e;

    localparam logic [4:0] ZERO_REG = 5'd0;
    localparam logic       TRUE     = 1'b1;
    localparam logic       FALSE    = 1'b0;

endpackage

// File: rtl/hazard_detect.sv
// Load-use comparator: ID reads a register that the load in EX has not yet produced.
module hazard_detect
    import sys_defs::*;
(
    input  logic       i_id_valid,
    input  logic [4:0] i_id_ra_idx,
    input  logic [4:0] i_id_rb_idx,
    input  logic       i_id_uses_ra,
    input  logic       i_id_uses_rb,
    input  logic       i_ex_valid,
    input  logic       i_ex_rd_mem,
    input  logic [4:0] i_ex_dest_idx,
    output logic       o_load_use
);

    logic w_ra_hit;
    logic w_rb_hit;

    assign w_ra_hit   = i_id_uses_ra & (i_id_ra_idx == i_ex_dest_idx);
    assign w_rb_hit   = i_id_uses_rb & (i_id_rb_idx == i_ex_dest_idx);
    // x0 is never written, so a load targeting it cannot create a hazard.
    assign o_load_use = i_id_valid & i_ex_valid & i_ex_rd_mem
                      & (i_ex_dest_idx != ZERO_REG) & (w_ra_hit | w_rb_hit);

endmodule

// File: rtl/pipeline_ctrl.sv
// Hazard, flush and EBREAK-halt sequencing for the 5-stage pipeline, with
// stall/flush performance counters.
module pipeline_ctrl
    import sys_defs::*;
#(
    parameter int DRAIN_DEPTH = 3,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             id_valid_inst,
    input  logic [4:0]       id_ra_idx,
    input  logic [4:0]       id_rb_idx,
    input  logic             id_uses_ra,
    input  logic             id_uses_rb,
    input  logic             id_halt,
    input  logic             ex_valid_inst,
    input  logic             ex_rd_mem,
    input  logic [4:0]       ex_dest_reg_idx,
    input  logic             ex_take_branch,
    input  logic             mem_busy,
    output logic             pc_stall,
    output logic             if_id_stall,
    output logic             if_id_flush,
    output logic             id_ex_bubble,
    output logic             ex_mem_stall,
    output logic             halted,
    output logic [1:0]       state_out,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    localparam int                DCNT_W     = (DRAIN_DEPTH > 1) ? $clog2(DRAIN_DEPTH) : 1;
    localparam logic [DCNT_W-1:0] DRAIN_LOAD = DCNT_W'(DRAIN_DEPTH - 1);

    ctrl_state_e       r_state;
    logic [DCNT_W-1:0] r_drain_cnt;
    logic [CNT_W-1:0]  r_stall_cnt;
    logic [CNT_W-1:0]  r_flush_cnt;

    logic w_load_use;
    logic w_br;
    logic w_halt_req;
    logic w_pc_stall;
    logic w_if_id_stall;
    logic w_if_id_flush;
    logic w_id_ex_bubble;
    logic w_ex_mem_stall;

    hazard_detect u_hazard (
        .i_id_valid    (id_valid_inst),
        .i_id_ra_idx   (id_ra_idx),
        .i_id_rb_idx   (id_rb_idx),
        .i_id_uses_ra  (id_uses_ra),
        .i_id_uses_rb  (id_uses_rb),
        .i_ex_valid    (ex_valid_inst),
        .i_ex_rd_mem   (ex_rd_mem),
        .i_ex_dest_idx (ex_dest_reg_idx),
        .o_load_use    (w_load_use)
    );

    assign w_br       = ex_valid_inst & ex_take_branch;
    assign w_halt_req = id_valid_inst & id_halt;

    // MEM_WAIT shares RUN's decode so the release cycle acts with no extra latency.
    always_comb begin
        w_pc_stall     = FALSE;
        w_if_id_stall  = FALSE;
        w_if_id_flush  = FALSE;
        w_id_ex_bubble = FALSE;
        w_ex_mem_stall = FALSE;
        if (rst) begin
            case (r_state)
                CTRL_RUN, CTRL_MEM_WAIT: begin
                    if (mem_busy) begin
                        w_pc_stall     = TRUE;
                        w_if_id_stall  = TRUE;
                        w_ex_mem_stall = TRUE;
                    end else if (w_br) begin
                        w_if_id_flush  = TRUE;
                        w_id_ex_bubble = TRUE;
                    end else if (w_load_use || w_halt_req) begin
                        w_pc_stall     = TRUE;
                        w_if_id_stall  = TRUE;
                        w_id_ex_bubble = TRUE;
                    end
                end
                CTRL_DRAIN: begin
                    w_pc_stall     = TRUE;
                    w_if_id_stall  = TRUE;
                    w_id_ex_bubble = TRUE;
                    w_ex_mem_stall = mem_busy;
                end
                CTRL_HALTED: begin
                    w_pc_stall     = TRUE;
                    w_if_id_stall  = TRUE;
                    w_ex_mem_stall = TRUE;
                end
                default: begin
                    w_pc_stall     = FALSE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= CTRL_RUN;
            r_drain_cnt <= '0;
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            if (w_pc_stall && (r_state != CTRL_HALTED)) begin
                r_stall_cnt <= r_stall_cnt + CNT_W'(1);
            end
            if (w_if_id_flush) begin
                r_flush_cnt <= r_flush_cnt + CNT_W'(1);
            end
            case (r_state)
                CTRL_RUN, CTRL_MEM_WAIT: begin
                    if (mem_busy) begin
                        r_state <= CTRL_MEM_WAIT;
                    end else if (!w_br && !w_load_use && w_halt_req) begin
                        r_state     <= CTRL_DRAIN;
                        r_drain_cnt <= DRAIN_LOAD;
                    end else begin
                        r_state <= CTRL_RUN;
                    end
                end
                CTRL_DRAIN: begin
                    if (!mem_busy) begin
                        if (r_drain_cnt == '0) begin
                            r_state <= CTRL_HALTED;
                        end else begin
                            r_drain_cnt <= r_drain_cnt - DCNT_W'(1);
                        end
                    end
                end
                CTRL_HALTED: begin
                    r_state <= CTRL_HALTED;
                end
                default: begin
                    r_state <= CTRL_RUN;
                end
            endcase
        end
    end

    assign pc_stall     = w_pc_stall;
    assign if_id_stall  = w_if_id_stall;
    assign if_id_flush  = w_if_id_flush;
    assign id_ex_bubble = w_id_ex_bubble;
    assign ex_mem_stall = w_ex_mem_stall;
    assign halted       = (r_state == CTRL_HALTED);
    assign state_out    = r_state;
    assign stall_cnt    = r_stall_cnt;
    assign flush_cnt    = r_flush_cnt;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Bench for pipeline_ctrl: directed scenarios plus randomized traffic against a behavioural model.
module tb_pipeline_ctrl;

    localparam int DRAIN_DEPTH = 3;
    localparam int CNT_W       = 32;
    localparam int S_RUN = 0, S_MEMW = 1, S_DRAIN = 2, S_HALT = 3;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       id_valid_inst, id_uses_ra, id_uses_rb, id_halt;
    logic [4:0] id_ra_idx, id_rb_idx, ex_dest_reg_idx;
    logic       ex_valid_inst, ex_rd_mem, ex_take_branch, mem_busy;

    logic             pc_stall, if_id_stall, if_id_flush, id_ex_bubble, ex_mem_stall, halted;
    logic [1:0]       state_out;
    logic [CNT_W-1:0] stall_cnt, flush_cnt;

    pipeline_ctrl #(.DRAIN_DEPTH(DRAIN_DEPTH), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst),
        .id_valid_inst(id_valid_inst), .id_ra_idx(id_ra_idx), .id_rb_idx(id_rb_idx),
        .id_uses_ra(id_uses_ra), .id_uses_rb(id_uses_rb), .id_halt(id_halt),
        .ex_valid_inst(ex_valid_inst), .ex_rd_mem(ex_rd_mem), .ex_dest_reg_idx(ex_dest_reg_idx),
        .ex_take_branch(ex_take_branch), .mem_busy(mem_busy),
        .pc_stall(pc_stall), .if_id_stall(if_id_stall), .if_id_flush(if_id_flush),
        .id_ex_bubble(id_ex_bubble), .ex_mem_stall(ex_mem_stall), .halted(halted),
        .state_out(state_out), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;

    // Reference model: state number, non-busy drain cycles still owed, counters.
    int               m_state;
    int               m_drain_left;
    logic [CNT_W-1:0] m_stall, m_flush;
    logic [7:0]       e_ctl;
    logic [7:0]       obs_ctl;

    assign obs_ctl = {pc_stall, if_id_stall, if_id_flush, id_ex_bubble, ex_mem_stall, halted, state_out};

    task automatic model_reset();
        m_state      = S_RUN;
        m_drain_left = 0;
        m_stall      = '0;
        m_flush      = '0;
    endtask

    // Expected {pc_stall, if_id_stall, if_id_flush, id_ex_bubble, ex_mem_stall, halted, state}.
    task automatic model_expect();
        logic lu, br, p, s, f, b, m;
        lu = id_valid_inst && ex_valid_inst && ex_rd_mem && (ex_dest_reg_idx != 5'd0) &&
             ((id_uses_ra && id_ra_idx == ex_dest_reg_idx) || (id_uses_rb && id_rb_idx == ex_dest_reg_idx));
        br = ex_valid_inst && ex_take_branch;
        {p, s, f, b, m} = 5'b0;
        if (rst) begin
            if (m_state == S_RUN || m_state == S_MEMW) begin
                if (mem_busy)                          {p, s, m} = 3'b111;
                else if (br)                           {f, b} = 2'b11;
                else if (lu || (id_valid_inst && id_halt)) {p, s, b} = 3'b111;
            end else if (m_state == S_DRAIN) begin
                {p, s, b} = 3'b111;
                m = mem_busy;
            end else begin
                {p, s, m} = 3'b111;
            end
        end
        e_ctl = {p, s, f, b, m, (m_state == S_HALT), 2'(m_state)};
    endtask

    task automatic model_step();
        logic lu, br;
        if (!rst) return;
        model_expect();
        lu = e_ctl[7] && e_ctl[4] && !e_ctl[3];
        br = e_ctl[5];
        if (e_ctl[7] && m_state != S_HALT) m_stall = m_stall + 1;
        if (br) m_flush = m_flush + 1;
        case (m_state)
            S_RUN, S_MEMW: begin
                if (mem_busy) m_state = S_MEMW;
                else if (!br && lu && id_valid_inst && id_halt &&
                         !(ex_valid_inst && ex_rd_mem && ex_dest_reg_idx != 5'd0 &&
                           ((id_uses_ra && id_ra_idx == ex_dest_reg_idx) ||
                            (id_uses_rb && id_rb_idx == ex_dest_reg_idx)))) begin
                    m_state      = S_DRAIN;
                    m_drain_left = DRAIN_DEPTH;
                end else m_state = S_RUN;
            end
            S_DRAIN: begin
                if (!mem_busy) begin
                    m_drain_left = m_drain_left - 1;
                    if (m_drain_left == 0) m_state = S_HALT;
                end
            end
            default: m_state = S_HALT;
        endcase
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
    endtask

    task automatic idle_inputs();
        {id_valid_inst, id_uses_ra, id_uses_rb, id_halt} = 4'b0;
        {ex_valid_inst, ex_rd_mem, ex_take_branch, mem_busy} = 4'b0;
        id_ra_idx = 5'd0; id_rb_idx = 5'd0; ex_dest_reg_idx = 5'd0;
    endtask

    task automatic set_load_use();
        idle_inputs();
        id_valid_inst = 1'b1; id_uses_ra = 1'b1; id_ra_idx = 5'd5;
        ex_valid_inst = 1'b1; ex_rd_mem = 1'b1; ex_dest_reg_idx = 5'd5;
    endtask

    task automatic rand_inputs();
        id_valid_inst   = ($urandom_range(0, 3) != 0);
        id_uses_ra      = ($urandom_range(0, 1) == 0);
        id_uses_rb      = ($urandom_range(0, 1) == 0);
        id_halt         = ($urandom_range(0, 15) == 0);
        id_ra_idx       = 5'($urandom_range(0, 3));
        id_rb_idx       = 5'($urandom_range(0, 3));
        ex_valid_inst   = ($urandom_range(0, 3) != 0);
        ex_rd_mem       = ($urandom_range(0, 1) == 0);
        ex_dest_reg_idx = 5'($urandom_range(0, 3));
        ex_take_branch  = ($urandom_range(0, 3) == 0);
        mem_busy        = ($urandom_range(0, 3) == 0);
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        idle_inputs();
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        model_reset();
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            rand_inputs();
            #1;
            n_cmp++;
            if (obs_ctl !== 8'h00 || stall_cnt !== '0 || flush_cnt !== '0) begin
                n_fail++;
                $display("FAIL reset[%0d]: ctl=%b stall=%0d flush=%0d, want ctl=00000000 stall=0 flush=0",
                         k, obs_ctl, stall_cnt, flush_cnt);
            end
        end
        @(negedge clk);
        idle_inputs();
        rst = 1'b1;
    endtask

    task automatic test_load_use();
        logic [7:0] want [3] = '{8'hD0, 8'h00, 8'h00};
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            set_load_use();
            if (k == 1) ex_valid_inst = 1'b0;
            if (k == 2) begin ex_dest_reg_idx = 5'd0; id_ra_idx = 5'd0; end
            #1;
            model_expect();
            n_cmp++;
            if (obs_ctl !== want[k] || stall_cnt !== m_stall || flush_cnt !== m_flush) begin
                n_fail++;
                $display("FAIL load_use[%0d]: ctl=%b stall=%0d flush=%0d, want ctl=%b stall=%0d flush=%0d",
                         k, obs_ctl, stall_cnt, flush_cnt, want[k], m_stall, m_flush);
            end
            tick();
        end
    endtask

    task automatic test_branch_vs_load_use();
        logic [7:0] want [2] = '{8'h30, 8'h00};
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            if (k == 0) begin set_load_use(); ex_take_branch = 1'b1; end
            else idle_inputs();
            #1;
            model_expect();
            n_cmp++;
            if (obs_ctl !== want[k] || stall_cnt !== m_stall || flush_cnt !== m_flush) begin
                n_fail++;
                $display("FAIL branch_vs_lu[%0d]: ctl=%b stall=%0d flush=%0d, want ctl=%b stall=%0d flush=%0d",
                         k, obs_ctl, stall_cnt, flush_cnt, want[k], m_stall, m_flush);
            end
            tick();
        end
    endtask

    task automatic test_mem_wait();
        logic [7:0] want [6] = '{8'hC8, 8'hC9, 8'hC9, 8'hC9, 8'h31, 8'h00};
        logic [CNT_W-1:0] s0, f0;
        s0 = m_stall;
        f0 = m_flush;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            idle_inputs();
            if (k < 5) begin ex_valid_inst = 1'b1; ex_take_branch = 1'b1; end
            mem_busy = (k < 4);
            #1;
            model_expect();
            n_cmp++;
            if (obs_ctl !== want[k] || stall_cnt !== m_stall || flush_cnt !== m_flush) begin
                n_fail++;
                $display("FAIL mem_wait[%0d]: ctl=%b stall=%0d flush=%0d, want ctl=%b stall=%0d flush=%0d",
                         k, obs_ctl, stall_cnt, flush_cnt, want[k], m_stall, m_flush);
            end
            tick();
        end
        #1;
        n_cmp++;
        if (stall_cnt - s0 !== CNT_W'(4) || flush_cnt - f0 !== CNT_W'(1)) begin
            n_fail++;
            $display("FAIL mem_wait_counts: stall delta=%0d flush delta=%0d, want 4 and 1",
                     stall_cnt - s0, flush_cnt - f0);
        end
    endtask

    task automatic test_halt();
        logic [7:0] want [8] = '{8'hD0, 8'hD2, 8'hD2, 8'hD2, 8'hCF, 8'hCF, 8'hCF, 8'hCF};
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (k == 0) begin idle_inputs(); id_valid_inst = 1'b1; id_halt = 1'b1; end
            else if (k < 4) begin idle_inputs(); ex_valid_inst = 1'b1; ex_take_branch = 1'b1; end
            else begin rand_inputs(); mem_busy = 1'b0; end
            #1;
            model_expect();
            n_cmp++;
            if (obs_ctl !== want[k] || stall_cnt !== m_stall || flush_cnt !== m_flush) begin
                n_fail++;
                $display("FAIL halt[%0d]: ctl=%b stall=%0d flush=%0d, want ctl=%b stall=%0d flush=%0d",
                         k, obs_ctl, stall_cnt, flush_cnt, want[k], m_stall, m_flush);
            end
            tick();
        end
    endtask

    task automatic test_reset_mid_drain();
        logic [7:0] want [6] = '{8'hD0, 8'hD2, 8'h00, 8'h00, 8'hD0, 8'h00};
        pulse_reset();
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            idle_inputs();
            if (k == 0) begin id_valid_inst = 1'b1; id_halt = 1'b1; end
            if (k == 2) begin rst = 1'b0; model_reset(); end
            if (k == 3) rand_inputs();
            if (k == 4) begin rst = 1'b1; set_load_use(); end
            #1;
            model_expect();
            n_cmp++;
            if (obs_ctl !== want[k] || stall_cnt !== m_stall || flush_cnt !== m_flush) begin
                n_fail++;
                $display("FAIL reset_mid_drain[%0d]: ctl=%b stall=%0d flush=%0d, want ctl=%b stall=%0d flush=%0d",
                         k, obs_ctl, stall_cnt, flush_cnt, want[k], m_stall, m_flush);
            end
            tick();
        end
    endtask

    task automatic test_random();
        int halt_cycles = 0;
        for (int k = 0; k < 800; k++) begin
            @(negedge clk);
            halt_cycles = (m_state == S_HALT) ? halt_cycles + 1 : 0;
            rst = !((halt_cycles > 4) || ($urandom_range(0, 99) == 0));
            if (!rst) begin model_reset(); halt_cycles = 0; end
            rand_inputs();
            #1;
            model_expect();
            n_cmp++;
            if (obs_ctl !== e_ctl || stall_cnt !== m_stall || flush_cnt !== m_flush) begin
                n_fail++;
                $display("FAIL random[%0d]: ctl=%b stall=%0d flush=%0d, want ctl=%b stall=%0d flush=%0d",
                         k, obs_ctl, stall_cnt, flush_cnt, e_ctl, m_stall, m_flush);
            end
            tick();
        end
    endtask

    initial begin
        idle_inputs();
        model_reset();
        test_reset();
        test_load_use();
        test_branch_vs_load_use();
        test_mem_wait();
        test_halt();
        test_reset_mid_drain();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
